// File: rtl/div_unit.sv
// div_unit
// Iterative radix-2 restoring divider for the execute stage. A DIV/DIVU
// request is accepted in IDLE. Non-zero divisors take one shift/subtract step
// per cycle for WIDTH cycles. A zero divisor short-circuits through DIVZERO.
// The result is then held in END for as long as the stalled pipeline keeps
// start_i high.
//
// Ports:
//   clk        core clock, rising edge
//   rst        synchronous, active-high reset
//   start_i    division request, held until ready_o is seen
//   signed_i   1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   annul_i    abort the current or pending operation (pipeline flush)
//   opdata1_i  dividend, sampled in IDLE
//   opdata2_i  divisor, sampled in IDLE
//   result_o   {remainder, quotient}, valid while ready_o = 1
//   ready_o    result valid
//   busy_o     unit is computing (DIVZERO or ON); drives the stall logic
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        ON,
        END
    } divState_t;

    divState_t         state;
    divState_t         nextState;

    logic [CW-1:0]     counter;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  dividend;
    logic [WIDTH-1:0]  divisor;
    logic              negQuot;
    logic              negRem;

    logic              dividendNeg;
    logic              divisorNeg;
    logic [WIDTH-1:0]  absDividend;
    logic [WIDTH-1:0]  absDivisor;
    logic              divisorZero;

    logic [WIDTH:0]    accShift;
    logic              trialOk;
    logic [WIDTH-1:0]  trialDiff;
    logic [WIDTH-1:0]  stepAcc;
    logic [WIDTH-1:0]  stepQuot;
    logic [WIDTH-1:0]  fixQuot;
    logic [WIDTH-1:0]  fixRem;
    logic              lastStep;

    // Operand conditioning for the IDLE latch. Signed operands are reduced
    // to magnitudes. The most negative value maps onto itself, which is
    // still the correct magnitude when read as unsigned.
    assign dividendNeg = signed_i && opdata1_i[WIDTH-1];
    assign divisorNeg  = signed_i && opdata2_i[WIDTH-1];
    assign absDividend = dividendNeg ? -opdata1_i : opdata1_i;
    assign absDivisor  = divisorNeg  ? -opdata2_i : opdata2_i;
    assign divisorZero = (opdata2_i == '0);

    // One restoring step. The shifted accumulator can need WIDTH+1 bits, so
    // the compare is done at that width. When the compare succeeds, the true
    // difference is below the divisor, and the low WIDTH bits of the
    // subtraction are exact.
    assign accShift  = {acc, dividend[WIDTH-1]};
    assign trialOk   = (accShift >= {1'b0, divisor});
    assign trialDiff = accShift[WIDTH-1:0] - divisor;
    assign stepAcc   = trialOk ? trialDiff : accShift[WIDTH-1:0];
    assign stepQuot  = {dividend[WIDTH-2:0], trialOk};
    assign lastStep  = (counter == CW'(WIDTH - 1));

    // Sign fix-up applied to the final step's results on the way into END.
    // The remainder follows the dividend's sign.
    assign fixQuot = negQuot ? -stepQuot : stepQuot;
    assign fixRem  = negRem  ? -stepAcc  : stepAcc;

    assign busy_o = (state == DIVZERO) || (state == ON);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode. Annul overrides every other transition, including
    // acceptance of a new request and completion of the last step.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    nextState = divisorZero ? DIVZERO : ON;
                end
            end
            DIVZERO: nextState = END;
            ON: begin
                if (lastStep) begin
                    nextState = END;
                end
            end
            END: begin
                if (!start_i) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (annul_i) begin
            nextState = IDLE;
        end
    end

    // Datapath and registered outputs. Operands are only captured in IDLE,
    // so input changes during a division are ignored. For a zero divisor,
    // the raw dividend bits are kept so they can be returned unmodified as
    // the remainder.
    always_ff @(posedge clk) begin
        if (rst || annul_i) begin
            counter  <= '0;
            acc      <= '0;
            dividend <= '0;
            divisor  <= '0;
            negQuot  <= 1'b0;
            negRem   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        counter  <= '0;
                        acc      <= '0;
                        divisor  <= absDivisor;
                        dividend <= divisorZero ? opdata1_i : absDividend;
                        negQuot  <= dividendNeg ^ divisorNeg;
                        negRem   <= dividendNeg;
                    end
                end
                DIVZERO: begin
                    result_o <= {dividend, {WIDTH{1'b1}}};
                    ready_o  <= 1'b1;
                end
                ON: begin
                    acc      <= stepAcc;
                    dividend <= stepQuot;
                    counter  <= counter + 1'b1;
                    if (lastStep) begin
                        result_o <= {fixRem, fixQuot};
                        ready_o  <= 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit
// Self-checking bench for div_unit (WIDTH = 32). Expected results come from a
// plain-arithmetic reference using 64-bit signed division. Latency, busy time,
// the handshake hold, annul and reset behaviour are also checked.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           signed_i;
    logic           annul_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;

    int vecCount = 0;
    int errCount = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .annul_i   (annul_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic. SV division truncates toward zero,
    // and the remainder takes the dividend's sign, which matches DIV.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'h0) begin
            return {a, 32'hFFFF_FFFF};
        end
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Launch one division, hold start through the result for holdCycles,
    // then release. Operand inputs are scrambled after acceptance to confirm
    // that they are not resampled.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn, input string tag, input int holdCycles);
        logic [63:0] expRes;
        logic [63:0] heldRes;
        int edges;
        int busyCnt;
        expRes    = refDiv(a, b, sgn);
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = sgn;
        start_i   = 1'b1;
        tick();
        edges     = 1;
        busyCnt   = 0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = 1'($urandom_range(1, 0));
        while (!ready_o && edges < 100) begin
            if (busy_o) busyCnt++;
            tick();
            edges++;
        end
        checkOutput({tag, " latency"}, edges, (b == 32'h0) ? 2 : 33);
        checkOutput({tag, " busy"}, busyCnt, (b == 32'h0) ? 1 : 32);
        checkOutput({tag, " result"}, result_o, expRes);
        heldRes = result_o;
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkOutput({tag, " hold ready"}, ready_o, 1);
            checkOutput({tag, " hold result"}, result_o, heldRes);
        end
        start_i = 1'b0;
        tick();
        checkOutput({tag, " release ready"}, ready_o, 0);
        checkOutput({tag, " release result"}, result_o, 0);
        tick();
        checkOutput({tag, " no relaunch"}, {ready_o, busy_o}, 0);
    endtask

    // Abort a division after ten steps using annul (useReset = 0) or rst
    // (useReset = 1). Then confirm that no result appears and that a fresh
    // request still works.
    task automatic abortTest(input logic useReset, input string tag);
        logic sawReady;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        signed_i  = 1'b0;
        start_i   = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        checkOutput({tag, " busy before abort"}, busy_o, 1);
        start_i = 1'b0;
        if (useReset) rst = 1'b1;
        else          annul_i = 1'b1;
        tick();
        rst     = 1'b0;
        annul_i = 1'b0;
        checkOutput({tag, " outputs after abort"}, {result_o, ready_o, busy_o}, 0);
        sawReady = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) sawReady = 1'b1;
        end
        checkOutput({tag, " ready never rose"}, sawReady, 0);
        applyStimulus(32'd1000, 32'd3, 1'b0, {tag, " relaunch"}, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        annul_i   = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        tick();
        tick();
        checkOutput("reset outputs", {result_o, ready_o, busy_o}, 0);
        rst = 1'b0;
        tick();

        applyStimulus(32'd100,        32'd7,        1'b0, "u 100/7",        5);
        applyStimulus(32'hFFFF_FFF9,  32'd2,        1'b1, "s -7/2",         0);
        applyStimulus(32'd7,          32'hFFFF_FFFE, 1'b1, "s 7/-2",        0);
        applyStimulus(32'h8000_0000,  32'hFFFF_FFFF, 1'b1, "s min/-1",      0);
        applyStimulus(32'hFFFF_FFFF,  32'd1,        1'b0, "u max/1",        0);
        applyStimulus(32'hFFFF_FFFF,  32'h8000_0001, 1'b0, "u max/big",     0);
        applyStimulus(32'h1234_5678,  32'd0,        1'b0, "u div0",         2);
        applyStimulus(32'h8765_4321,  32'd0,        1'b1, "s div0",         0);

        abortTest(1'b0, "annul");
        abortTest(1'b1, "reset");

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        sgn;
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(3, 0) == 0) b = b >> $urandom_range(31, 0);
            if ($urandom_range(15, 0) == 0) b = 32'h0;
            sgn = 1'($urandom_range(1, 0));
            applyStimulus(a, b, sgn, $sformatf("rand%0d", n), $urandom_range(2, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
